scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Keypad column scanner. A free-running 2-bit column index is decoded into an active-low one-hot column drive.
- The block senses the 4 active-low row lines and priority-encodes any pressed row, using the same rule as the team's 4-to-2 priority encoder: the highest asserted index wins.
- A press is accepted only after debounce. It is reported as a 4-bit {row, col} code with a one-cycle valid pulse.
- Sits between the keypad pins and the keypad consumer logic (display / command decode).

Parameters:
- SCAN_DIV, default 4: clk cycles each column is driven before advancing. Legal range 3 or more, which covers the synchronizer latency.
- DEBOUNCE_CYCLES, default 4: consecutive cycles of stable synchronized row value required to accept a press or a release. Legal range 1 to 255.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: scan enable.
- row, input, 4: raw keypad row sense, active-low, asynchronous.
- col, output, 4: column drive, active-low one-hot.
- col_idx, output, 2: index of the currently driven column.
- key_code, output, 4: {row_idx[1:0], col_idx[1:0]} of the last accepted key.
- key_valid, output, 1: one-cycle pulse when key_code updates.
- busy, output, 1: high from acceptance of a key until its release is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - state = SCAN, col_idx = 0, col = 4'hE.
  - key_code = 0, key_valid = 0, busy = 0.
  - Dwell counter and debounce counter = 0; synchronizer flops = 4'hF.
- Reset is honoured in every state, including mid-DEBOUNCE and mid-HOLD. It never generates a key_valid pulse.
- Synchronizer: row passes through 2 flops to give row_s. All decisions use row_s. "Pressed" means row_s != 4'hF.
- Row encode: row_idx = index of the highest-numbered zero bit of row_s. Example: row_s = 4'b0101 gives row_idx = 3.
- col is registered. col = ~(4'b0001 << col_idx) whenever enable = 1.
- SCAN state:
  - Dwell counter counts 0 to SCAN_DIV-1.
  - Sampling happens only on dwell count SCAN_DIV-1.
  - If pressed: go to DEBOUNCE, freeze col_idx, capture row_s as the reference, set debounce count to 1.
  - If not pressed: col_idx increments mod 4 (3 wraps to 0) and the dwell counter clears.
- DEBOUNCE state:
  - row_s == reference: count increments.
  - row_s == 4'hF: return to SCAN. Dwell counter clears; col_idx is unchanged. No pulse.
  - row_s is a different non-F value: the reference reloads and the count resets to 1.
  - When count == DEBOUNCE_CYCLES: on the next edge, key_code = {row_idx(reference), col_idx}, key_valid = 1 for exactly one cycle, busy = 1, go to HOLD.
- HOLD state:
  - col stays frozen.
  - When row_s == 4'hF: go to RELEASE with release count = 1.
- RELEASE state:
  - Each cycle with row_s == 4'hF increments the release count.
  - Any pressed cycle returns to HOLD. No new pulse.
  - When count == DEBOUNCE_CYCLES: busy = 0, go to SCAN, col_idx advances by 1, dwell counter clears.
- enable = 0, from any state:
  - Next edge: state = SCAN, col = 4'hF (all columns idle), dwell counter held at 0, col_idx held.
  - key_valid = 0, busy = 0. key_code retains its value.
  - When enable returns to 1, scanning resumes at the held col_idx with a full dwell.
- key_code changes only together with key_valid. At most one pulse per physical press.
- Latency: a row edge reaches row_s 2 cycles later. From the first qualifying sample to key_valid is DEBOUNCE_CYCLES cycles.

Test Plan (SCAN_DIV = 4, DEBOUNCE_CYCLES = 4; the bench keypad model drives row from col and the pressed-key matrix):
- Reset, no keys -> col = E, E, E, E, then D, then B, then 7, then E (wrap), 4 cycles each. key_valid never asserts.
- Key at row 2 / col 1 held -> col freezes at D, exactly one key_valid pulse with key_code = 4'h9, busy = 1 until 4 cycles after row_s returns to F, then col advances to B.
- Bounce: key low for 2 cycles then released during DEBOUNCE -> no pulse, busy stays 0, scan resumes on col D with a full 4-cycle dwell.
- Rows 3 and 1 pressed together on col 2 (row = 4'b0101) -> key_code = 4'hE. A release glitch of 2 cycles inside RELEASE returns to HOLD with no second pulse.
- reset asserted for one cycle mid-HOLD -> next cycle col = E, col_idx = 0, busy = 0, key_code = 0, key_valid = 0.
- enable dropped during SCAN at col_idx 2 -> col = F, no pulses while a key is pressed. enable raised -> col = B, full 4-cycle dwell, then detection proceeds normally.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: keypad column scanner with row priority encode, debounce and one-cycle key pulse
module scan_decoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       busy
);
  localparam int DW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] sync1, row_s, ref_r, ref_n, key_code_n;
  logic [1:0] col_idx_n, ref_idx;
  logic busy_n, valid_n, pressed, dwell_end, cnt_end;
  assign pressed = row_s != 4'hF;
  assign dwell_end = dwell == DW'(SCAN_DIV - 1);
  assign cnt_end = cnt == 8'(DEBOUNCE_CYCLES);
  assign ref_idx = !ref_r[3] ? 2'd3 : !ref_r[2] ? 2'd2 : !ref_r[1] ? 2'd1 : 2'd0;
  always_comb begin
    state_n = state;
    dwell_n = dwell;
    cnt_n = cnt;
    ref_n = ref_r;
    col_idx_n = col_idx;
    key_code_n = key_code;
    busy_n = busy;
    valid_n = 1'b0;
    if (!enable) begin
      state_n = SCAN;
      dwell_n = '0;
      busy_n = 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (col != 4'hF) begin
            if (!dwell_end) dwell_n = dwell + 1'b1;
            else if (pressed) begin
              state_n = DEBOUNCE;
              ref_n = row_s;
              cnt_n = 8'd1;
            end else begin
              col_idx_n = col_idx + 1'b1;
              dwell_n = '0;
            end
          end
        end
        DEBOUNCE: begin
          if (cnt_end) begin
            state_n = HOLD;
            key_code_n = {ref_idx, col_idx};
            valid_n = 1'b1;
            busy_n = 1'b1;
          end else if (!pressed) begin
            state_n = SCAN;
            dwell_n = '0;
          end else if (row_s == ref_r) cnt_n = cnt + 8'd1;
          else begin
            ref_n = row_s;
            cnt_n = 8'd1;
          end
        end
        HOLD: begin
          if (!pressed) begin
            state_n = RELEASE;
            cnt_n = 8'd1;
          end
        end
        RELEASE: begin
          if (cnt_end) begin
            state_n = SCAN;
            busy_n = 1'b0;
            col_idx_n = col_idx + 1'b1;
            dwell_n = '0;
          end else if (pressed) state_n = HOLD;
          else cnt_n = cnt + 8'd1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
      col_idx <= 2'd0;
      col <= 4'hE;
      key_code <= 4'h0;
      key_valid <= 1'b0;
      busy <= 1'b0;
      dwell <= '0;
      cnt <= 8'd0;
      ref_r <= 4'hF;
      sync1 <= 4'hF;
      row_s <= 4'hF;
    end else begin
      state <= state_n;
      col_idx <= col_idx_n;
      col <= enable ? ~(4'b0001 << col_idx_n) : 4'hF;
      key_code <= key_code_n;
      key_valid <= valid_n;
      busy <= busy_n;
      dwell <= dwell_n;
      cnt <= cnt_n;
      ref_r <= ref_n;
      sync1 <= row;
      row_s <= sync1;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed keypad-matrix bench for scan_decoder
module tb_scan_decoder;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [3:0] row, col, key_code;
  logic [1:0] col_idx;
  logic key_valid, busy;
  logic [3:0] keys [4];
  int cyc = 0, pulses = 0, tests = 0, fails = 0;
  scan_decoder #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .row(row), .col(col),
    .col_idx(col_idx), .key_code(key_code), .key_valid(key_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
      if (key_valid) pulses++;
    end
  endtask
  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask
  initial begin
    logic [3:0] e;
    clear_keys();
    repeat (2) @(negedge clk);
    check("rst_col", col, 4'hE);
    check("rst_idx", col_idx, 2'd0);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      goto(i);
      e = ~(4'b0001 << ((i / 4) % 4));
      check("scan_col", col, e);
    end
    check("scan_pulses", pulses, 0);
    pulses = 0;
    keys[2][1] = 1'b1;
    goto(27);
    check("k21_pre_col", col, 4'hD);
    check("k21_pre_valid", key_valid, 1'b0);
    goto(28);
    check("k21_valid", key_valid, 1'b1);
    check("k21_code", key_code, 4'h9);
    check("k21_busy", busy, 1'b1);
    goto(29);
    check("k21_pulse_end", key_valid, 1'b0);
    clear_keys();
    goto(35);
    check("k21_rel_busy", busy, 1'b1);
    check("k21_rel_col", col, 4'hD);
    goto(36);
    check("k21_idle_busy", busy, 1'b0);
    check("k21_next_col", col, 4'hB);
    check("k21_pulses", pulses, 1);
    pulses = 0;
    goto(49);
    keys[0][1] = 1'b1;
    goto(51);
    clear_keys();
    goto(53);
    check("bnc_busy", busy, 1'b0);
    check("bnc_col53", col, 4'hD);
    goto(57);
    check("bnc_col57", col, 4'hD);
    goto(58);
    check("bnc_col58", col, 4'hB);
    check("bnc_pulses", pulses, 0);
    pulses = 0;
    keys[3][2] = 1'b1;
    keys[1][2] = 1'b1;
    goto(65);
    check("k32_pre_valid", key_valid, 1'b0);
    goto(66);
    check("k32_valid", key_valid, 1'b1);
    check("k32_code", key_code, 4'hE);
    goto(67);
    clear_keys();
    goto(70);
    keys[3][2] = 1'b1;
    keys[1][2] = 1'b1;
    goto(72);
    clear_keys();
    goto(74);
    check("glitch_busy74", busy, 1'b1);
    goto(78);
    check("glitch_busy78", busy, 1'b1);
    check("glitch_col78", col, 4'hB);
    goto(79);
    check("glitch_busy79", busy, 1'b0);
    check("glitch_col79", col, 4'h7);
    check("glitch_pulses", pulses, 1);
    keys[0][3] = 1'b1;
    goto(87);
    check("k03_valid", key_valid, 1'b1);
    check("k03_code", key_code, 4'h3);
    goto(89);
    check("k03_hold_busy", busy, 1'b1);
    reset = 1'b1;
    clear_keys();
    goto(90);
    reset = 1'b0;
    check("mid_rst_col", col, 4'hE);
    check("mid_rst_idx", col_idx, 2'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    goto(99);
    enable = 1'b0;
    goto(100);
    check("dis_col", col, 4'hF);
    check("dis_idx", col_idx, 2'd2);
    pulses = 0;
    keys[2][2] = 1'b1;
    goto(106);
    check("dis_col106", col, 4'hF);
    check("dis_code", key_code, 4'h0);
    check("dis_pulses", pulses, 0);
    enable = 1'b1;
    goto(107);
    check("en_col107", col, 4'hB);
    goto(110);
    check("en_col110", col, 4'hB);
    goto(114);
    check("en_pre_valid", key_valid, 1'b0);
    check("en_pre_code", key_code, 4'h0);
    goto(115);
    check("en_valid", key_valid, 1'b1);
    check("en_code", key_code, 4'hA);
    check("en_busy", busy, 1'b1);
    goto(116);
    enable = 1'b0;
    goto(117);
    check("dis2_col", col, 4'hF);
    check("dis2_busy", busy, 1'b0);
    check("dis2_code", key_code, 4'hA);
    check("dis2_valid", key_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
